// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel types, used by the scan generator and
// by the sprite ROMs that consume its coordinates.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Half-open interval test: lo <= v < hi.
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Tick-enabled column/row scan counters. The column wraps at H_TOT-1 and
// advances the row, which in turn wraps at V_TOT-1 on the same tick.
module vga_scan_counter
    import vga_pkg::*;
#(
    parameter int H_TOT = H_TOTAL,
    parameter int V_TOT = V_TOTAL
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   tick_i,
    output coord_t column_o,
    output coord_t row_o,
    output logic   frame_wrap_o
);

    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);

    coord_t column_q, column_d;
    coord_t row_q, row_d;
    logic   col_last, row_last;

    always_comb begin
        col_last = (column_q == H_LAST);
        row_last = (row_q == V_LAST);
        column_d = column_q;
        row_d    = row_q;
        if (tick_i) begin
            if (col_last) begin
                column_d = '0;
                row_d    = row_last ? '0 : row_q + coord_t'(1);
            end else begin
                column_d = column_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            column_q <= '0;
            row_q    <= '0;
        end else begin
            column_q <= column_d;
            row_q    <= row_d;
        end
    end

    assign column_o     = column_q;
    assign row_o        = row_q;
    assign frame_wrap_o = tick_i & col_last & row_last;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: scan coordinates out, registered RGB444 and
// active-low syncs back. Define VGA_CLK_DIV_EN for an internal divide-by-2 pixel tick.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pixel_colour,
    output logic [10:0] row,
    output logic [10:0] column,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam int     H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    logic tick;

`ifdef VGA_CLK_DIV_EN
    logic phase_q;

    // Phase starts at 0 after reset, so the first tick lands on the 2nd edge.
    always_ff @(posedge clk) begin
        if (reset) phase_q <= 1'b0;
        else       phase_q <= ~phase_q;
    end

    assign tick = phase_q;
`else
    assign tick = 1'b1;
`endif

    coord_t col_cnt, row_cnt;
    logic   frame_wrap;

    vga_scan_counter #(
        .H_TOT(H_TOT),
        .V_TOT(V_TOT)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick),
        .column_o    (col_cnt),
        .row_o       (row_cnt),
        .frame_wrap_o(frame_wrap)
    );

    logic video_on_q, video_on_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic frame_start_q, frame_start_d;
    rgb_t rgb_q, rgb_d;
    logic visible;

    always_comb begin
        visible       = (col_cnt < H_VIS_C) && (row_cnt < V_VIS_C);
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        // Cleared on the next clk even when that edge is not a tick.
        frame_start_d = frame_wrap;
        if (tick) begin
            video_on_d = visible;
            hsync_d    = ~in_span(col_cnt, HS_START, HS_END);
            vsync_d    = ~in_span(row_cnt, VS_START, VS_END);
            rgb_d      = visible ? rgb_t'(pixel_colour) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row         = row_cnt;
    assign column      = col_cnt;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken 15x8 raster (visible 8x4,
// hsync cols 10..12, vsync rows 5..6) so whole frames run quickly.
module tb_vga_sync_gen;

    localparam int HV = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VV = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int H_TOT = 15;
    localparam int V_TOT = 8;
    localparam int FRAME = 120;
    localparam int HS_LO = 10, HS_HI = 12;
    localparam int VS_LO = 5, VS_HI = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_colour;
    logic [10:0] row, column;
    logic        video_on, hsync, vsync, frame_start;
    logic [3:0]  red, green, blue;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_colour(pixel_colour),
        .row         (row),
        .column      (column),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one pixel tick and stop on the following falling edge.
    task automatic tick();
`ifdef VGA_CLK_DIV_EN
        @(posedge clk);
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_row"}, row, 0);
        check({tag, "_col"}, column, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_video_on"}, video_on, 0);
        check({tag, "_rgb"}, {red, green, blue}, 0);
        check({tag, "_frame_start"}, frame_start, 0);
    endtask

    initial begin : stimulus
        int m_row, m_col, p_row, p_col;
        int hs_low, vs_low, fs_cnt, fs_first, fs_second;
        logic [11:0] pc;
        logic p_vis;

        reset = 1'b1;
        pixel_colour = 12'h000;
        repeat (3) begin
            @(negedge clk);
            check_reset_state("reset_hold");
        end
        reset = 1'b0;

        // Two full frames against a spec-level raster model: first frame solid red.
        m_row = 0; m_col = 0;
        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int t = 0; t < 2 * FRAME; t++) begin
            pc = (t < FRAME) ? 12'hF00 : 12'($urandom_range(0, 4095));
            pixel_colour = pc;
            p_row = m_row;
            p_col = m_col;
            p_vis = (p_col < HV) && (p_row < VV);
            tick();
            if (m_col == H_TOT - 1) begin
                m_col = 0;
                m_row = (m_row == V_TOT - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
            check("scan_col", column, m_col);
            check("scan_row", row, m_row);
            check("video_on", video_on, p_vis);
            check("hsync", hsync, !((p_col >= HS_LO) && (p_col <= HS_HI)));
            check("vsync", vsync, !((p_row >= VS_LO) && (p_row <= VS_HI)));
            check("rgb", {red, green, blue}, p_vis ? pc : 12'h000);
            check("frame_start", frame_start, (p_row == V_TOT - 1) && (p_col == H_TOT - 1));
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = t;
                else fs_second = t;
            end
        end
        check("hsync_low_ticks", hs_low, 2 * V_TOT * HS);
        check("vsync_low_ticks", vs_low, 2 * VS * H_TOT);
        check("frame_start_count", fs_cnt, 2);
        check("frame_start_first", fs_first, FRAME - 1);
        check("frame_start_spacing", fs_second - fs_first, FRAME);

        // Run to row 3 / column 5, then a single-cycle mid-frame reset.
        pixel_colour = 12'h0A5;
        repeat (3 * H_TOT + 5) tick();
        check("pre_reset_row", row, 3);
        check("pre_reset_col", column, 5);
        check("pre_reset_video_on", video_on, 1);
        check("pre_reset_rgb", {red, green, blue}, 12'h0A5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("mid_reset");

        // Scan resumes from (0,0); column steps every clk, or every 2nd with the divider.
        @(posedge clk);
        @(negedge clk);
`ifdef VGA_CLK_DIV_EN
        check("div_first_edge_col", column, 0);
        check("div_first_edge_video_on", video_on, 0);
        @(posedge clk);
        @(negedge clk);
`endif
        check("resume_col", column, 1);
        check("resume_row", row, 0);
        check("resume_video_on", video_on, 1);
        check("resume_rgb", {red, green, blue}, 12'h0A5);
        @(posedge clk);
        @(negedge clk);
`ifdef VGA_CLK_DIV_EN
        check("div_hold_col", column, 1);
`else
        check("nodiv_step_col", column, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
